// File: rtl/img_pkg.sv
// img_pkg: shared FSM states, pixel tag layout and frame-size helper for the ROM frame reader
package img_pkg;
    localparam int TAG_CH_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    typedef struct packed {
        logic                sol;
        logic                eol;
        logic                eoc;
        logic                eof;
        logic [TAG_CH_W-1:0] ch;
    } tag_t;
    function automatic longint frame_size(int ch, int win);
        return longint'(ch) * win * win;
    endfunction
endpackage

// File: rtl/img_rom_reader_if.sv
// img_rom_reader_if: valid/ready pixel stream with position flags
interface img_rom_reader_if #(parameter int WIDTH = 16, parameter int CHW = 2);
    logic [WIDTH-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_sol;
    logic             pix_eol;
    logic             pix_eoc;
    logic             pix_eof;
    logic [CHW-1:0]   pix_ch;
    modport master(output pix_data, pix_valid, pix_sol, pix_eol, pix_eoc, pix_eof, pix_ch, input pix_ready);
    modport slave(input pix_data, pix_valid, pix_sol, pix_eol, pix_eoc, pix_eof, pix_ch, output pix_ready);
endinterface

// File: rtl/img_skid_fifo.sv
// img_skid_fifo: 2-entry FIFO whose head entry is always in e0 so outputs come straight from a register
module img_skid_fifo #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d, slot;
    always_comb begin
        slot  = cnt_q - {1'b0, pop};
        e0_d  = (push && slot == 2'd0) ? din : pop ? e1_q : e0_q;
        e1_d  = (push && slot == 2'd1) ? din : e1_q;
        cnt_d = slot + {1'b0, push};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end
    assign head  = e0_q;
    assign count = cnt_q;
endmodule

// File: rtl/img_rom_reader.sv
// img_rom_reader: scans the pixel ROM channel/row/column and streams pixels with credit-based backpressure
module img_rom_reader import img_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int CH    = 3,
    parameter int WIN   = 256,
    parameter int ADDR  = 18,
    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1,
    localparam int PW   = (WIN > 1) ? $clog2(WIN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR-1:0]    rom_addr,
    input  logic [WIDTH-1:0]   rom_data,
    img_rom_reader_if.master   pix,
    output logic               busy,
    output logic               done
);
    if (frame_size(CH, WIN) > (longint'(1) << ADDR)) begin : g_size_chk
        $error("img_rom_reader: CH*WIN*WIN exceeds ROM address space");
    end
    state_e          state_q, state_d;
    logic [PW-1:0]   col_q, col_d, row_q, row_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic            infl_q, done_q, done_d, pop, issue, col_end, row_end, last;
    tag_t            tag_q, tag_d, tag_h;
    logic [1:0]      cnt;
    logic [WIDTH+$bits(tag_t)-1:0] head;
    always_comb begin
        pop     = pix.pix_valid & pix.pix_ready;
        // occupancy after this cycle's pop must leave room for the read about to be issued
        issue   = state_q == RUN && ({1'b0, cnt} + {2'b0, infl_q} - {2'b0, pop}) < 3'd2;
        col_end = col_q == PW'(WIN - 1);
        row_end = row_q == PW'(WIN - 1);
        last    = col_end && row_end && ch_q == CHW'(CH - 1);
        tag_d   = '{sol: col_q == '0, eol: col_end, eoc: col_end && row_end, eof: last, ch: TAG_CH_W'(ch_q)};
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        if (state_q == IDLE && start) begin
            state_d = RUN;
            col_d   = '0;
            row_d   = '0;
            ch_d    = '0;
            addr_d  = '0;
        end
        if (issue) begin
            col_d   = col_end ? '0 : col_q + 1'b1;
            row_d   = col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
            ch_d    = (col_end && row_end) ? ch_q + 1'b1 : ch_q;
            addr_d  = addr_q + 1'b1;
            state_d = last ? DRAIN : RUN;
        end
        // leave DRAIN on the cycle the final pixel transfers so done lands in IDLE
        if (state_q == DRAIN && !infl_q && cnt == {1'b0, pop}) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
            infl_q  <= 1'b0;
            tag_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            infl_q  <= issue;
            tag_q   <= tag_d;
            done_q  <= done_d;
        end
    end
    img_skid_fifo #(.W(WIDTH + $bits(tag_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (infl_q),
        .pop   (pop),
        .din   ({rom_data, tag_q}),
        .head  (head),
        .count (cnt)
    );
    assign {pix.pix_data, tag_h} = head;
    assign pix.pix_valid = cnt != 2'd0;
    assign pix.pix_sol   = tag_h.sol;
    assign pix.pix_eol   = tag_h.eol;
    assign pix.pix_eoc   = tag_h.eoc;
    assign pix.pix_eof   = tag_h.eof;
    assign pix.pix_ch    = CHW'(tag_h.ch);
    assign rom_addr      = addr_q;
    assign busy          = state_q != IDLE;
    assign done          = done_q;
endmodule

// File: tb/tb_img_rom_reader.sv
// tb_img_rom_reader: directed frames with random backpressure checked against an index-based pixel model
module tb_img_rom_reader;
    localparam int WIDTH = 8, CH = 2, WIN = 4, ADDR = 5, N = CH * WIN * WIN;
    logic clk = 0, rst = 1, start = 0, busy, done;
    logic [ADDR-1:0]  rom_addr;
    logic [WIDTH-1:0] rom_data;
    int total = 0, bad = 0;
    img_rom_reader_if #(.WIDTH(WIDTH), .CHW(1)) pix();
    img_rom_reader #(.WIDTH(WIDTH), .CH(CH), .WIN(WIN), .ADDR(ADDR)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pix      (pix),
        .busy     (busy),
        .done     (done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= WIDTH'(rom_addr);
    function automatic logic [31:0] snap();
        return {18'b0, pix.pix_valid, pix.pix_data, pix.pix_sol, pix.pix_eol, pix.pix_eoc, pix.pix_eof, pix.pix_ch};
    endfunction
    function automatic logic [31:0] model(int i);
        return {18'b0, 1'b1, WIDTH'(i), (i % WIN == 0), (i % WIN == WIN - 1),
                (i % (WIN * WIN) == WIN * WIN - 1), (i == N - 1), 1'(i / (WIN * WIN))};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // mode 0: ready=1, 1: random ready, 2: ready low cycles 2..11, 3: extra start at 10, 4: reset at 12
    task automatic frame(input int mode, output int first_c, output int done_c);
        int idx = 0, last_x = -1;
        int xc[3] = '{-1, -1, -1};
        logic held = 0;
        logic [31:0] prev = '0;
        first_c = -1;
        done_c  = -1;
        for (int c = 0; c < 400 && done_c < 0; c++) begin
            start = (c == 0) || (mode == 3 && c == 10);
            pix.pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 2) ? !(c >= 2 && c < 12) : 1'b1;
            if (held) chk("hold", snap(), prev);
            if (pix.pix_valid && first_c < 0) first_c = c;
            if (pix.pix_valid && pix.pix_ready) begin
                chk("pixel", snap(), model(idx));
                if (idx < 3) xc[idx] = c;
                idx++;
                last_x = c;
            end
            held = pix.pix_valid && !pix.pix_ready;
            prev = snap();
            if (c == 1) chk("busy_run", 32'(busy), 1);
            if (mode == 2 && c == 11) chk("stall_issues", 32'(rom_addr), 2);
            if (mode == 4 && c == 12) begin
                #3 rst = 1;
                #1 chk("async_rst", {pix.pix_valid, busy, done}, 0);
                @(posedge clk);
                #1 rst = 0;
                start = 0;
                return;
            end
            if (c > 0 && done) begin
                done_c = c;
                chk("busy_done", 32'(busy), 0);
            end else step();
        end
        start = 0;
        chk("done_seen", 32'(done_c > 0), 1);
        chk("pixel_count", idx, N);
        if (mode == 0 || mode == 3) chk("last_xfer", last_x, N + 2);
        if (mode == 2) chk("resume", {xc[0][7:0], xc[1][7:0], xc[2][7:0]}, {8'd12, 8'd13, 8'd14});
    endtask
    initial begin
        int f, d;
        pix.pix_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pix", snap(), 0);
        chk("reset_ctl", {busy, done, rom_addr}, 0);
        rst = 0;
        step();
        frame(0, f, d);
        chk("first_valid", f, 3);
        chk("done_cycle", d, N + 3);
        frame(0, f, d);
        chk("restart_first", f, 3);
        chk("restart_done", d, N + 3);
        repeat (3) step();
        frame(1, f, d);
        chk("rand_first", f, 3);
        frame(2, f, d);
        chk("stall_first", f, 3);
        frame(3, f, d);
        chk("ignore_start_done", d, N + 3);
        frame(4, f, d);
        for (int i = 0; i < 5; i++) begin
            chk("post_rst", {pix.pix_valid, done, busy}, 0);
            step();
        end
        frame(0, f, d);
        chk("replay_first", f, 3);
        chk("replay_done", d, N + 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
